// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: memory access sizes, data-memory responder states,
// load funct3 encodings and the byte-lane helpers used by the MEM stage.
package riscv_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } dmem_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // The unused encoding 2'b11 behaves as a word access.
   function automatic mem_size_t decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return MEM_B;
         2'b01:   return MEM_H;
         default: return MEM_W;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] lane);
      case (size)
         MEM_B:   return 4'b0001 << lane;
         MEM_H:   return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
      case (size)
         MEM_H:   return lane[0];
         MEM_W:   return lane != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_t size,
                                               input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*lane +: 8];
      h = word[16*lane[1] +: 16];
      case (size)
         MEM_B:   return {{24{~uns & b[7]}}, b};
         MEM_H:   return {{16{~uns & h[15]}}, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data storage: byte-lane synchronous write and a registered read
// sharing one word address (reads and writes never happen in the same cycle).
module dmem_array #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic                     rd_en,
   input  logic [3:0]               be,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   // NOTE: the storage array has no reset; clearing DEPTH words would force flops instead of RAM.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       rdata <= '0;
      else if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, response after LATENCY cycles.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned accesses via rsp_err instead of forcing alignment.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic          we;
      mem_size_t     size;
      logic          uns;
      logic          err;
      logic [AW+1:0] addr;
      logic [31:0]   wdata;
   } req_t;

   dmem_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q;
   logic        accept;
   logic        acc_err;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        unused_addr_hi;

   // Addresses wrap modulo DEPTH words, so the upper address bits are dropped.
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign accept    = req_valid & req_ready;

`ifdef DMEM_MISALIGN_ERR_EN
   assign acc_err = is_misaligned(decode_size(req_size), req_addr[1:0]);
   assign rsp_err = rsp_valid & req_q.err;
`else
   assign acc_err = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               cnt_d   = 4'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q <= '0;
      end else if (accept) begin
         req_q <= '{we:    req_we,
                    size:  decode_size(req_size),
                    uns:   req_unsigned,
                    err:   acc_err,
                    addr:  req_addr[AW+1:0],
                    wdata: req_wdata};
      end
   end

   // Store data is replicated across lanes; the byte enables pick the live ones.
   always_comb begin
      wr_data = req_q.wdata;
      case (req_q.size)
         MEM_B:   wr_data = {4{req_q.wdata[7:0]}};
         MEM_H:   wr_data = {2{req_q.wdata[15:0]}};
         default: wr_data = req_q.wdata;
      endcase
   end

   assign wr_be = (rsp_valid && req_q.we && !req_q.err) ? lane_mask(req_q.size, req_q.addr[1:0])
                                                         : 4'b0000;

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .addr  (req_q.addr[AW+1:2]),
      .rd_en (state_q == BUSY),
      .be    (wr_be),
      .wdata (wr_data),
      .rdata (rd_data)
   );

   assign rsp_rdata = (req_q.we || req_q.err) ? 32'h0
                    : load_extend(rd_data, req_q.size, req_q.addr[1:0], req_q.uns);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;
   import riscv_pkg::*;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;
   localparam int BOUND   = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] mdl [DEPTH*4];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   // ---------------- reference model ----------------
   function automatic int nbytes_of(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_ERR_EN
      int n;
      n = nbytes_of(sz);
      return (a % n) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int unsigned model_base(input logic [1:0] sz, input logic [31:0] a);
      int unsigned ba;
      int unsigned n;
      n  = nbytes_of(sz);
      ba = a % (DEPTH * 4);
      return ba - (ba % n);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] a);
      int          n;
      int unsigned base;
      longint      v;
      n    = nbytes_of(sz);
      base = model_base(sz, a);
      v    = 0;
      for (int i = 0; i < n; i++) v += longint'(mdl[base + i]) << (8 * i);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int          n;
      int unsigned base;
      n    = nbytes_of(sz);
      base = model_base(sz, a);
      for (int i = 0; i < n; i++) mdl[base + i] = wd[8*i +: 8];
   endtask

   // ---------------- bus tasks ----------------
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      int w;
      w = 0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rsp_pulse: rsp_valid=%b before accept, required 0", rsp_valid);
      end
      while (req_ready !== 1'b1 && w < BOUND) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (w != 0) begin
         bad++;
         $display("FAIL accept_wait: waited %0d cycles for req_ready, required 0", w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input bit hold, output logic [31:0] rd, output logic err);
      int c;
      bit ready_bad;
      c         = 0;
      ready_bad = 1'b0;
      @(negedge clk);
      if (!hold) begin
         req_valid    = 1'b0;
         req_we       = 1'($urandom_range(0, 1));
         req_size     = 2'($urandom_range(0, 3));
         req_unsigned = 1'($urandom_range(0, 1));
         req_addr     = $urandom;
         req_wdata    = $urandom;
      end
      while (rsp_valid !== 1'b1 && c < BOUND) begin
         if (req_ready !== 1'b0) ready_bad = 1'b1;
         @(negedge clk);
         c++;
      end
      if (req_ready !== 1'b0) ready_bad = 1'b1;
      total++;
      if (c != LATENCY) begin
         bad++;
         $display("FAIL latency: rsp_valid after %0d cycles, required %0d", c, LATENCY);
      end
      total++;
      if (ready_bad) begin
         bad++;
         $display("FAIL ready_busy: req_ready high during BUSY/RESP, required 0");
      end
      rd  = rsp_rdata;
      err = rsp_err;
   endtask

   task automatic check_rsp(input string name, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a,
                            input logic [31:0] rd, input logic err);
      bit          perr;
      logic [31:0] exp_rd;
      perr   = model_err(sz, a);
      exp_rd = (we || perr) ? 32'h0 : model_load(sz, uns, a);
      total++;
      if (err !== perr) begin
         bad++;
         $display("FAIL %s_err: addr=%h got %b required %b", name, a, err, perr);
      end
      total++;
      if (rd !== exp_rd) begin
         bad++;
         $display("FAIL %s_rdata: addr=%h got %h required %h", name, a, rd, exp_rd);
      end
      if (we && !perr) model_store(sz, a, req_wdata_of_last);
   endtask

   logic [31:0] req_wdata_of_last;

   task automatic access(input string name, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
      issue(we, sz, uns, a, wd);
      collect(1'b0, rd, err);
      req_wdata_of_last = wd;
      check_rsp(name, we, sz, uns, a, rd, err);
   endtask

   task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] rd;
      logic        err;
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (2) @(negedge clk);
      expect32("reset_ready", {31'h0, req_ready}, 32'h1);
      expect32("reset_valid", {31'h0, rsp_valid}, 32'h0);
      expect32("reset_rdata", rsp_rdata, 32'h0);
      expect32("reset_err", {31'h0, rsp_err}, 32'h0);
      rst = 1'b1;
      access("rst_seed", 1'b1, F3_LW[1:0], 1'b0, 32'h40, 32'h1111_1111, rd, err);
      issue(1'b1, F3_LW[1:0], 1'b0, 32'h40, 32'h2222_2222);
      req_valid = 1'b0;
      rst       = 1'b0;
      #1;
      expect32("midreset_ready", {31'h0, req_ready}, 32'h1);
      expect32("midreset_valid", {31'h0, rsp_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      access("rst_load", 1'b0, F3_LW[1:0], 1'b0, 32'h40, 32'h0, rd, err);
      expect32("midreset_nowrite", rd, 32'h1111_1111);
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      logic        err;
      access("sw", 1'b1, F3_LW[1:0], 1'b0, 32'h10, 32'hDEAD_BEEF, rd, err);
      access("lw", 1'b0, F3_LW[1:0], 1'b0, 32'h10, 32'h0, rd, err);
      expect32("lw_deadbeef", rd, 32'hDEAD_BEEF);
   endtask

   task automatic test_byte();
      logic [31:0] rd;
      logic        err;
      access("sw0", 1'b1, F3_LW[1:0], 1'b0, 32'h20, 32'h0, rd, err);
      access("sb", 1'b1, F3_LB[1:0], 1'b0, 32'h21, 32'h0000_0080, rd, err);
      access("lb", 1'b0, F3_LB[1:0], F3_LB[2], 32'h21, 32'h0, rd, err);
      expect32("lb_sext", rd, 32'hFFFF_FF80);
      access("lbu", 1'b0, F3_LBU[1:0], F3_LBU[2], 32'h21, 32'h0, rd, err);
      expect32("lbu_zext", rd, 32'h0000_0080);
      access("lw_b", 1'b0, F3_LW[1:0], 1'b0, 32'h20, 32'h0, rd, err);
      expect32("lw_after_sb", rd, 32'h0000_8000);
   endtask

   task automatic test_half();
      logic [31:0] rd;
      logic        err;
      access("sw0h", 1'b1, F3_LW[1:0], 1'b0, 32'h30, 32'h0, rd, err);
      access("sh", 1'b1, F3_LH[1:0], 1'b0, 32'h32, 32'h0000_8001, rd, err);
      access("lh", 1'b0, F3_LH[1:0], F3_LH[2], 32'h32, 32'h0, rd, err);
      expect32("lh_sext", rd, 32'hFFFF_8001);
      access("lhu", 1'b0, F3_LHU[1:0], F3_LHU[2], 32'h32, 32'h0, rd, err);
      expect32("lhu_zext", rd, 32'h0000_8001);
      access("lw_h", 1'b0, F3_LW[1:0], 1'b0, 32'h30, 32'h0, rd, err);
      expect32("lw_after_sh", rd, 32'h8001_0000);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic        err;
      issue(1'b1, F3_LW[1:0], 1'b0, 32'h50, 32'hA5A5_0F0F);
      model_store(F3_LW[1:0], 32'h50, 32'hA5A5_0F0F);
      // Second request held on the bus for the whole first transaction.
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = F3_LW[1:0];
      req_unsigned = 1'b0;
      req_addr     = 32'h50 + DEPTH * 4;
      collect(1'b1, rd, err);
      expect32("b2b_store_rdata", rd, 32'h0);
      issue(1'b0, F3_LW[1:0], 1'b0, 32'h50 + DEPTH * 4, 32'h0);
      collect(1'b0, rd, err);
      expect32("b2b_alias_load", rd, 32'hA5A5_0F0F);
      access("alias_sw", 1'b1, F3_LW[1:0], 1'b0, 32'h54 + 3 * DEPTH * 4, 32'h1234_5678, rd, err);
      access("alias_lw", 1'b0, F3_LW[1:0], 1'b0, 32'h54, 32'h0, rd, err);
      expect32("alias_wrap", rd, 32'h1234_5678);
   endtask

`ifdef DMEM_MISALIGN_ERR_EN
   task automatic test_misalign();
      logic [31:0] rd;
      logic        err;
      access("mis_lw", 1'b0, F3_LW[1:0], 1'b0, 32'h13, 32'h0, rd, err);
      expect32("mis_lw_err", {31'h0, err}, 32'h1);
      expect32("mis_lw_rdata", rd, 32'h0);
      access("mis_sw", 1'b1, F3_LW[1:0], 1'b0, 32'h12, 32'h5555_5555, rd, err);
      expect32("mis_sw_err", {31'h0, err}, 32'h1);
      access("mis_chk", 1'b0, F3_LW[1:0], 1'b0, 32'h10, 32'h0, rd, err);
      expect32("mis_sw_nowrite", rd, 32'hDEAD_BEEF);
   endtask
`endif

   task automatic test_random();
      logic [31:0] rd;
      logic        err;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) begin
         access("rnd_init", 1'b1, F3_LW[1:0], 1'b0, 32'h400 + 32'(4 * i), $urandom, rd, err);
      end
      for (int i = 0; i < 80; i++) begin
         a = 32'($urandom_range(0, 7)) * DEPTH * 4 + 32'h400
           + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
         access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom, rd, err);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_byte();
      test_half();
      test_back_to_back();
`ifdef DMEM_MISALIGN_ERR_EN
      test_misalign();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
